// File: rtl/branch_resolve.sv
// branch_resolve: resolves B, BL, B.cond, CBZ and CBNZ in the branch stage.
// It computes the taken target and registers a one-cycle redirect to fetch,
// a flush that lasts FLUSH_CYCLES cycles to squash wrong-path instructions,
// and a one-cycle link-register write for BL.
// Optional feature macro: BRANCH_STATS_EN adds saturating taken/not-taken counters.
// Ports:
//   clk, reset             clock; asynchronous active-high reset
//   valid_in, br_type      branch-stage valid and branch kind (0 NONE,1 B,2 BL,3 BCOND,4 CBZ,5 CBNZ)
//   cond, imm26, imm19     condition field and word offsets
//   pc_in, rt_val          branch PC and forwarded Rt value
//   negative..carry_out    stored NZCV flags
//   ALU_*, flag_fwd_en     flags of the EX-stage flag-setting op and their select
//   redirect, redirect_pc  fetch redirect pulse and target
//   flush                  squash younger instructions
//   link_we, link_val      X30 write pulse and value (pc_in + 4)
//   taken_count, not_taken_count  statistics (BRANCH_STATS_EN only)
module branch_resolve #(
  parameter int unsigned PC_W         = 64,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned STAT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [2:0]        br_type,
  input  logic [3:0]        cond,
  input  logic [25:0]       imm26,
  input  logic [18:0]       imm19,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [PC_W-1:0]   rt_val,
  input  logic              negative,
  input  logic              zero,
  input  logic              overflow,
  input  logic              carry_out,
  input  logic              ALU_negative,
  input  logic              ALU_zero,
  input  logic              ALU_overflow,
  input  logic              ALU_carry_out,
  input  logic              flag_fwd_en,
`ifdef BRANCH_STATS_EN
  output logic [STAT_W-1:0] taken_count,
  output logic [STAT_W-1:0] not_taken_count,
`endif
  output logic              redirect,
  output logic [PC_W-1:0]   redirect_pc,
  output logic              flush,
  output logic              link_we,
  output logic [PC_W-1:0]   link_val
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               redirect_q, redirect_d;
  logic               flush_q, flush_d;
  logic               link_we_q, link_we_d;
  logic [PC_W-1:0]    redirect_pc_q, redirect_pc_d;
  logic [PC_W-1:0]    link_val_q, link_val_d;

  logic n_c, z_c, c_c, v_c;
  logic cond_base_c, cond_true_c, taken_c, is_branch_c, accept_c;
  logic [PC_W-1:0] off26_c, off19_c, target_c;

  // Effective flags: forwarded from EX when a flag-setting op is in flight
  assign n_c = flag_fwd_en ? ALU_negative  : negative;
  assign z_c = flag_fwd_en ? ALU_zero      : zero;
  assign c_c = flag_fwd_en ? ALU_carry_out : carry_out;
  assign v_c = flag_fwd_en ? ALU_overflow  : overflow;

  // cond[3:1] selects the base test, cond[0] inverts it (except AL/NV)
  always_comb begin
    cond_base_c = 1'b0;
    case (cond[3:1])
      3'd0:    cond_base_c = z_c;
      3'd1:    cond_base_c = c_c;
      3'd2:    cond_base_c = n_c;
      3'd3:    cond_base_c = v_c;
      3'd4:    cond_base_c = c_c & ~z_c;
      3'd5:    cond_base_c = (n_c == v_c);
      3'd6:    cond_base_c = ~z_c & (n_c == v_c);
      default: cond_base_c = 1'b1;
    endcase
    cond_true_c = (cond[3:1] == 3'd7) ? 1'b1 : (cond_base_c ^ cond[0]);
  end

  // Taken decision per branch kind; encodings 6-7 behave as NONE
  always_comb begin
    taken_c     = 1'b0;
    is_branch_c = 1'b1;
    case (br_type)
      3'd1, 3'd2: taken_c = 1'b1;
      3'd3:       taken_c = cond_true_c;
      3'd4:       taken_c = (rt_val == '0);
      3'd5:       taken_c = (rt_val != '0);
      default:    is_branch_c = 1'b0;
    endcase
  end

  assign off26_c  = {{(PC_W-28){imm26[25]}}, imm26, 2'b00};
  assign off19_c  = {{(PC_W-21){imm19[18]}}, imm19, 2'b00};
  assign target_c = pc_in + ((br_type == 3'd1 || br_type == 3'd2) ? off26_c : off19_c);
  assign accept_c = (state_q == IDLE) && valid_in && taken_c;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      redirect_q    <= 1'b0;
      flush_q       <= 1'b0;
      link_we_q     <= 1'b0;
      redirect_pc_q <= '0;
      link_val_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      redirect_q    <= redirect_d;
      flush_q       <= flush_d;
      link_we_q     <= link_we_d;
      redirect_pc_q <= redirect_pc_d;
      link_val_q    <= link_val_d;
    end
  end

  // Next state: FLUSH spans the cycles during which flush is visible
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          cnt_d = CNT_W'(FLUSH_CYCLES - 1);
          if (FLUSH_CYCLES > 1) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Output next values; targets hold their last value between pulses
  always_comb begin
    redirect_d    = accept_c;
    flush_d       = accept_c || ((state_q == FLUSH) && (cnt_q != '0));
    redirect_pc_d = accept_c ? target_c : redirect_pc_q;
    link_we_d     = accept_c && (br_type == 3'd2);
    link_val_d    = link_we_d ? (pc_in + PC_W'(4)) : link_val_q;
  end

  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign flush       = flush_q;
  assign link_we     = link_we_q;
  assign link_val    = link_val_q;

`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] taken_cnt_q, not_taken_cnt_q;
  logic              stat_upd_c;

  // Only real branches seen while IDLE are counted; counters saturate
  assign stat_upd_c = (state_q == IDLE) && valid_in && is_branch_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      taken_cnt_q     <= '0;
      not_taken_cnt_q <= '0;
    end else if (stat_upd_c) begin
      if (taken_c && !(&taken_cnt_q))
        taken_cnt_q <= taken_cnt_q + STAT_W'(1);
      if (!taken_c && !(&not_taken_cnt_q))
        not_taken_cnt_q <= not_taken_cnt_q + STAT_W'(1);
    end
  end

  assign taken_count     = taken_cnt_q;
  assign not_taken_count = not_taken_cnt_q;
`endif

endmodule
